ifu: RTL

IFU -- requirements
Module: ifu

---
 rtl/npc_pkg.sv | 15 +
 rtl/ifu_perf_cnt.sv | 22 ++
 rtl/ifu.sv | 81 ++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the fetch front end: FSM state encoding and
// architectural constants used by ifu and its optional perf counters.
package npc_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } ifu_state_e;

    localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ifu_perf_cnt.sv
// Free-running fetch performance counters: accepted instructions and
// memory stall cycles. Both wrap at 2^32.
module ifu_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_evt,
    input  logic        wait_evt,
    output logic [31:0] fetch_cnt,
    output logic [31:0] wait_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (fetch_evt) fetch_cnt <= fetch_cnt + 32'd1;
            if (wait_evt)  wait_cnt  <= wait_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: REQ -> WAIT -> VALID loop, terminal HALT on ebreak.
// Define IFU_PERF_CNT_EN to add the fetch_cnt / wait_cnt counter outputs.
module ifu
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halt
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] wait_cnt
`endif
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic        handshake;
    logic        capture;

    assign handshake = (state_q == ST_VALID) && inst_ready;
    // Responses arriving in any other state are stale and must not land in ir_q.
    assign capture   = (state_q == ST_WAIT) && imem_rvalid;

    always_comb begin
        // NOTE: default assignment first, so no path through the case infers a latch.
        state_d = state_q;
        case (state_q)
            ST_REQ:   state_d = ST_WAIT;
            ST_WAIT:  if (imem_rvalid) state_d = ST_VALID;
            ST_VALID: if (inst_ready) state_d = (ir_q == EBREAK_INST) ? ST_HALT : ST_REQ;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_REQ;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (capture)   ir_q <= imem_rdata;
            if (handshake) pc_q <= redirect_valid ? redirect_pc : pc_q + 32'd4;
        end
    end

    assign imem_req   = (state_q == ST_REQ);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == ST_VALID);
    assign inst       = ir_q;
    assign pc         = pc_q;
    assign halt       = (state_q == ST_HALT);

`ifdef IFU_PERF_CNT_EN
    ifu_perf_cnt u_perf_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_evt (handshake),
        .wait_evt  ((state_q == ST_WAIT) && !imem_rvalid),
        .fetch_cnt (fetch_cnt),
        .wait_cnt  (wait_cnt)
    );
`endif

endmodule
